fetch_unit: RTL and testbench

Instruction-fetch stage directly downstream of the program counter: takes the current PC value, issues one read per instruction to instruction memory over a req/gnt/rvalid handshake, and presents the returned word with its address to decode over a valid/ready handshake. It drives the PC's hold input so the PC advances exactly once per instruction accepted by decode. Fetching the halt word, or a misaligned PC, stops the machine until reset.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_unit.sv | 102 ++++++++++
 tb/tb_fetch_unit.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// fetch_pkg : fetch-stage state encoding and halt/reset constants
// Rev 1.0
// ============================================================================
package fetch_pkg;

  typedef enum logic [2:0] {
    S_REQ  = 3'd0,
    S_WAIT = 3'd1,
    S_OUT  = 3'd2,
    S_HALT = 3'd3,
    S_ERR  = 3'd4
  } fetch_state_e;

  localparam logic [31:0] HALT_INSTR_DEFAULT = 32'hFC00_0000;
  localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// fetch_unit : one-request-at-a-time instruction fetch between PC and decode
// Rev 1.0
// ============================================================================
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] HALT_INSTR = HALT_INSTR_DEFAULT,
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  output logic        pc_hold,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        halted,
  output logic        misalign_err
);

  fetch_state_e r_state;
  logic [31:0]  r_instr;
  logic [31:0]  r_instr_pc;
  logic         r_valid;
  logic         r_halted;
  logic         r_misalign;

  logic w_pc_aligned;
  logic w_accept_next;

  assign w_pc_aligned = (pc_in[1:0] == 2'b00);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_REQ;
      r_instr    <= '0;
      r_instr_pc <= RESET_PC;
      r_valid    <= 1'b0;
      r_halted   <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      case (r_state)
        S_REQ: begin
          if (!w_pc_aligned) begin
            r_state    <= S_ERR;
            r_misalign <= 1'b1;
          end else if (imem_gnt) begin
            r_instr_pc <= pc_in;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            r_instr <= imem_rdata;
            r_valid <= 1'b1;
            r_state <= S_OUT;
          end
        end
        S_OUT: begin
          if (instr_ready) begin
            r_valid <= 1'b0;
            if (r_instr == HALT_INSTR) begin
              r_halted <= 1'b1;
              r_state  <= S_HALT;
            end else begin
              r_state <= S_REQ;
            end
          end
        end
        S_HALT, S_ERR: begin
          r_state <= r_state;
        end
        default: begin
          r_state <= S_REQ;
        end
      endcase
    end
  end

  // Reset gating keeps the PC frozen and memory idle while rst is held low.
  assign w_accept_next = rst && (r_state == S_OUT) && instr_ready
                         && (r_instr != HALT_INSTR);

  assign pc_hold      = !w_accept_next;
  assign imem_req     = rst && (r_state == S_REQ) && w_pc_aligned;
  assign imem_addr    = pc_in;
  assign instr_valid  = r_valid;
  assign instr        = r_instr;
  assign instr_pc     = r_instr_pc;
  assign halted       = r_halted;
  assign misalign_err = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// tb_fetch_unit : directed and randomized checks of fetch_unit against a
// program-memory / PC model. Rev 1.0
// ============================================================================
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] C_HALT = 32'hFC00_0000;

  logic        clk;
  logic        rst;
  logic [31:0] pc_in;
  logic        pc_hold;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        halted;
  logic        misalign_err;

  int n_asserts;
  int n_fail;
  logic [31:0] prog [16];

  fetch_unit #(
    .HALT_INSTR (C_HALT),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_in        (pc_in),
    .pc_hold      (pc_hold),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .halted       (halted),
    .misalign_err (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // The bench plays the PC register: it advances by 4 on any edge with pc_hold low.
  task automatic step();
    logic hold_prev;
    hold_prev = pc_hold;
    @(posedge clk);
    #1;
    if (!hold_prev) pc_in = pc_in + 32'd4;
  endtask

  // One instruction: g cycles without gnt, r cycles without rvalid, d cycles without ready.
  task automatic fetch_one(input logic [31:0] word, input logic [31:0] addr,
                           input int g, input int r, input int d);
    for (int i = 0; i <= g; i++) begin
      imem_gnt    = (i == g);
      imem_rvalid = 1'($urandom);
      imem_rdata  = $urandom;
      instr_ready = 1'($urandom);
      #1;
      chk("req_active", 32'(imem_req), 32'd1);
      chk("req_addr", imem_addr, addr);
      chk("req_hold", 32'(pc_hold), 32'd1);
      chk("req_valid", 32'(instr_valid), 32'd0);
      step();
    end
    for (int i = 0; i <= r; i++) begin
      imem_gnt    = 1'($urandom);
      imem_rvalid = (i == r);
      imem_rdata  = (i == r) ? word : $urandom;
      instr_ready = 1'($urandom);
      #1;
      chk("wait_req", 32'(imem_req), 32'd0);
      chk("wait_hold", 32'(pc_hold), 32'd1);
      chk("wait_valid", 32'(instr_valid), 32'd0);
      step();
    end
    for (int i = 0; i <= d; i++) begin
      imem_gnt    = 1'($urandom);
      imem_rvalid = 1'($urandom);
      imem_rdata  = $urandom;
      instr_ready = (i == d);
      #1;
      chk("out_valid", 32'(instr_valid), 32'd1);
      chk("out_instr", instr, word);
      chk("out_pc", instr_pc, addr);
      chk("out_req", 32'(imem_req), 32'd0);
      chk("out_hold", 32'(pc_hold), ((i == d) && (word != C_HALT)) ? 32'd0 : 32'd1);
      step();
    end
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    instr_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst         = 1'b0;
    imem_gnt    = 1'b1;
    imem_rvalid = 1'b1;
    instr_ready = 1'b1;
    imem_rdata  = 32'h1234_5678;
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_hold", 32'(pc_hold), 32'd1);
    step();
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_misalign", 32'(misalign_err), 32'd0);
    rst         = 1'b1;
    pc_in       = 32'd0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    instr_ready = 1'b0;
    #1;
    chk("post_rst_req", 32'(imem_req), 32'd1);
  endtask

  initial begin
    logic [31:0] w;
    n_asserts   = 0;
    n_fail      = 0;
    rst         = 1'b0;
    pc_in       = 32'd0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'd0;
    instr_ready = 1'b0;
    step();
    step();
    do_reset();

    // Best case, then stalled memory and stalled decode at the next PC.
    fetch_one(32'h2008_0005, 32'h0000_0000, 0, 0, 0);
    fetch_one(32'h3C01_1001, 32'h0000_0004, 3, 2, 4);

    // Halt word at 0x10: PC must never advance and no further requests.
    pc_in = 32'h0000_0010;
    fetch_one(C_HALT, 32'h0000_0010, 1, 0, 2);
    for (int i = 0; i < 4; i++) begin
      imem_gnt    = 1'($urandom);
      imem_rvalid = 1'($urandom);
      instr_ready = 1'b1;
      #1;
      chk("halt_flag", 32'(halted), 32'd1);
      chk("halt_valid", 32'(instr_valid), 32'd0);
      chk("halt_req", 32'(imem_req), 32'd0);
      chk("halt_hold", 32'(pc_hold), 32'd1);
      chk("halt_pc", pc_in, 32'h0000_0010);
      step();
    end
    do_reset();

    // Misaligned PC: no request, sticky error.
    pc_in    = 32'h0000_0006;
    imem_gnt = 1'b1;
    #1;
    chk("mis_req", 32'(imem_req), 32'd0);
    step();
    for (int i = 0; i < 4; i++) begin
      pc_in       = 32'h0000_0008;
      imem_gnt    = 1'b1;
      instr_ready = 1'($urandom);
      #1;
      chk("mis_flag", 32'(misalign_err), 32'd1);
      chk("mis_req_after", 32'(imem_req), 32'd0);
      chk("mis_hold", 32'(pc_hold), 32'd1);
      chk("mis_valid", 32'(instr_valid), 32'd0);
      step();
    end
    do_reset();

    // Reset in WAIT with rvalid asserted the same cycle: data discarded.
    pc_in    = 32'h0000_0020;
    imem_gnt = 1'b1;
    #1;
    chk("rw_req", 32'(imem_req), 32'd1);
    step();
    rst         = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    instr_ready = 1'b1;
    step();
    chk("rw_valid", 32'(instr_valid), 32'd0);
    chk("rw_instr", instr, 32'd0);
    chk("rw_instr_pc", instr_pc, 32'd0);
    rst         = 1'b1;
    pc_in       = 32'd0;
    imem_rvalid = 1'b0;
    instr_ready = 1'b0;
    #1;
    chk("rw_req_after", 32'(imem_req), 32'd1);
    chk("rw_addr_after", imem_addr, 32'd0);
    step();

    // Random program executed straight-line from address 0.
    for (int k = 0; k < 16; k++) begin
      w = $urandom;
      if (w == C_HALT) w = w ^ 32'd1;
      prog[k] = w;
    end
    for (int k = 0; k < 20; k++) begin
      fetch_one(prog[k % 16], 32'(k * 4), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3));
    end
    chk("rand_final_pc", pc_in, 32'd80);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
